bcd_countdown_ctrl: RTL
=======================

// Module: bcd_countdown_ctrl
// PURPOSE
//   Sequencing controller for the two-digit BCD countdown display path. Owns the
//   start/pause/done FSM, the 1 Hz count-enable prescaler and the BCD decrement of
//   tens/ones digits. Time-multiplexes the digits onto one 4-bit bus feeding the
//   BCD-to-7-segment decoder, with a digit-select output for the display anodes.
// PARAMETERS
//   CLK_DIV    100_000_000  clk cycles per count tick (1 Hz at 100 MHz); >=2
//   SCAN_DIV   100_000      clk cycles per digit-select toggle; >=2
//   INIT_TENS  4'd5         tens digit loaded at reset
//   INIT_ONES  4'd9         ones digit loaded at reset
// PORTS
//   clk        in   1  system clock
//   rst        in   1  reset, synchronous, active-high
//   start      in   1  1-cycle pulse: start / resume / acknowledge done
//   pause      in   1  1-cycle pulse: pause while running
//   load       in   1  1-cycle pulse: load load_tens/load_ones (IDLE only)
//   load_tens  in   4  BCD tens value to load
//   load_ones  in   4  BCD ones value to load
//   bcd_tens   out  4  current tens digit
//   bcd_ones   out  4  current ones digit
//   bcd_out    out  4  multiplexed digit for the 7-seg decoder
//   digit_sel  out  1  0 = ones shown on bcd_out, 1 = tens shown
//   running    out  1  high in RUN
//   done       out  1  high in DONE
// BEHAVIOUR
//   Reset: state IDLE; tens/ones = INIT_TENS/INIT_ONES; reload reg = same;
//     both prescalers 0; digit_sel 0; bcd_out = INIT_ONES; running 0; done 0.
//   All outputs registered; control inputs take effect on the next clk edge.
//   States: IDLE, RUN, PAUSE, DONE.
//   IDLE: load -> digits and reload reg take load values; any nibble >9 clamps to 9.
//     start with value 00 -> DONE; start otherwise -> RUN, count prescaler cleared.
//     start and load same cycle: load wins, start ignored.
//   RUN: count tick fires CLK_DIV cycles after RUN entry, then every CLK_DIV.
//     On tick: ones>0 -> ones-1; ones==0 -> ones=9, tens-1. Tick that yields 00
//     -> DONE on the same edge. pause -> PAUSE; pause+start same cycle -> PAUSE.
//     pause coinciding with tick: decrement applied, then PAUSE (or DONE if 00).
//   PAUSE: prescaler frozen (not cleared); start -> RUN, resuming the partial
//     count. start+pause same cycle -> stay PAUSE.
//   DONE: digits held at 00, done=1; start -> IDLE with digits = reload reg.
//   load ignored outside IDLE. pause ignored outside RUN.
//   Scan: free-running in every state; digit_sel toggles every SCAN_DIV cycles;
//     bcd_out = digit_sel ? tens : ones, updated same edge as digit_sel/digits.
//   rst mid-operation: full return to reset values next edge; reload reg too.
//   Digits never leave 0..9; tens never decrements below 0 (00 always exits RUN).
// STRUCTURE
//   Package bcd_ctrl_pkg: state encoding (IDLE=0,RUN=1,PAUSE=2,DONE=3),
//     BCD_MAX=4'd9, BCD digit width constant.
//   Sub-module tick_gen (params DIV; ports clk, rst, clr, en, tick): counter
//     0..DIV-1, 1-cycle tick at wrap; instantiated for count (en = RUN,
//     clr = RUN entry) and scan (en=1, clr=0).
//   FSM, BCD decrement and output mux in this module.
// TESTING (bench uses CLK_DIV=4, SCAN_DIV=3)
//   Reset -> bcd_tens=5, bcd_ones=9, done=0, running=0, digit_sel=0, bcd_out=9.
//   load 1,2; start -> running=1; after 4 clks 11, 8 clks 10, 12 clks 09
//     (borrow), continue to 00 -> done=1, running=0 same edge.
//   load 0,3; start; pause after 6 clks (value 02, 2 into period); hold 20 clks
//     -> 02 unchanged; start -> 01 exactly 2 clks later.
//   load 4'hC,4'hF -> digits 9,9; load during RUN -> ignored; pause+start in RUN
//     -> PAUSE.
//   DONE after load 0,1 run; start -> IDLE, digits 01; load 0,0 + start -> DONE.
//   Scan: digit_sel toggles every 3 clks; bcd_out tracks selected digit; rst
//     asserted mid-RUN -> all outputs at reset values on next edge.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD countdown controller.
package bcd_ctrl_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Any non-decimal nibble is treated as the largest legal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, tick is high during the wrap cycle.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Counter holds its value when disabled so a paused period resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD countdown: start/pause/done sequencing, 1 Hz decrement, digit scan mux.
module bcd_countdown_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned     CLK_DIV   = 100_000_000,
  parameter int unsigned     SCAN_DIV  = 100_000,
  parameter logic [BCD_W-1:0] INIT_TENS = 4'd5,
  parameter logic [BCD_W-1:0] INIT_ONES = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_ones,
  output logic [BCD_W-1:0] bcd_out,
  output logic             digit_sel,
  output logic             running,
  output logic             done
);

  state_t           state, state_n;
  logic [BCD_W-1:0] tens_n, ones_n;
  logic [BCD_W-1:0] reload_tens, reload_ones, reload_tens_n, reload_ones_n;
  logic [BCD_W-1:0] dec_tens, dec_ones;
  logic             sel_n;
  logic             count_tick, scan_tick, count_clr;
  logic             is_zero;

  assign is_zero   = (bcd_tens == '0) && (bcd_ones == '0);
  assign count_clr = (state == ST_IDLE) && start && !load && !is_zero;

  tick_gen #(.DIV(CLK_DIV)) u_count_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (count_clr),
    .en   (state == ST_RUN),
    .tick (count_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .en   (1'b1),
    .tick (scan_tick)
  );

  // One-step BCD decrement with borrow from the tens digit.
  always_comb begin
    dec_ones = (bcd_ones != '0) ? bcd_ones - BCD_W'(1) : BCD_MAX;
    dec_tens = (bcd_ones != '0) ? bcd_tens : bcd_tens - BCD_W'(1);
  end

  // Next-state, next-digit and scan-select decode.
  always_comb begin
    state_n       = state;
    tens_n        = bcd_tens;
    ones_n        = bcd_ones;
    reload_tens_n = reload_tens;
    reload_ones_n = reload_ones;
    sel_n         = digit_sel ^ scan_tick;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          tens_n        = bcd_clamp(load_tens);
          ones_n        = bcd_clamp(load_ones);
          reload_tens_n = bcd_clamp(load_tens);
          reload_ones_n = bcd_clamp(load_ones);
        end else if (start) begin
          state_n = is_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (count_tick) begin
          tens_n = dec_tens;
          ones_n = dec_ones;
        end
        // A tick reaching 00 takes priority over a coincident pause.
        if (count_tick && (dec_tens == '0) && (dec_ones == '0)) begin
          state_n = ST_DONE;
        end else if (pause) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start && !pause) begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_n = ST_IDLE;
          tens_n  = reload_tens;
          ones_n  = reload_ones;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, digits, reload value and all outputs registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bcd_tens    <= INIT_TENS;
      bcd_ones    <= INIT_ONES;
      reload_tens <= INIT_TENS;
      reload_ones <= INIT_ONES;
      digit_sel   <= 1'b0;
      bcd_out     <= INIT_ONES;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      bcd_tens    <= tens_n;
      bcd_ones    <= ones_n;
      reload_tens <= reload_tens_n;
      reload_ones <= reload_ones_n;
      digit_sel   <= sel_n;
      bcd_out     <= sel_n ? tens_n : ones_n;
      running     <= (state_n == ST_RUN);
      done        <= (state_n == ST_DONE);
    end
  end

endmodule
